// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the sum_bcd_display stage: FSM state encoding,
// the double-dabble iteration count, active-low 7-segment patterns and
// digit-select codes for the 2-digit common-anode display.
package sum_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One shift per binary input bit (5-bit adder result).
  localparam logic [2:0] ITER_COUNT = 3'd5;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit enables, active-low; bit0 = ones, bit1 = tens.
  localparam logic [1:0] DIG_ONES = 2'b10;
  localparam logic [1:0] DIG_TENS = 2'b01;

endpackage

// File: rtl/sum_bcd_display_seg7_decoder.sv
// seg7_decoder: combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   bcd  in  4  BCD digit (values above 9 produce a blank pattern)
//   seg  out 7  segment drive {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: captures the 5-bit adder result {cout_in, sum_in} on a
// start pulse, converts it to two BCD digits with an iterative
// shift-add-3 FSM, and scans both digits onto a common-anode display.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   sum_in   in  4  adder sum bits
//   cout_in  in  1  adder carry-out (weight 16)
//   start    in  1  capture-and-convert request
//   busy     out 1  conversion in progress (CONV or DONE)
//   done     out 1  one-cycle pulse when tens/ones are updated
//   tens     out 4  registered BCD tens digit
//   ones     out 4  registered BCD ones digit
//   seg      out 7  segment drive {g,f,e,d,c,b,a}, active-low
//   dig_sel  out 2  digit enables, active-low; bit0 = ones, bit1 = tens
// Handshake: start is honoured only while busy=0; a start seen while busy=1
// is dropped. done rises on the edge that updates tens/ones, six edges after
// the edge that sampled start.
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  // ---------------- conversion FSM ----------------
  // sr layout: [12:9] tens nibble, [8:5] ones nibble, [4:0] binary input.
  state_t      state, state_n;
  logic [12:0] sr, sr_n, adj;
  logic [2:0]  cnt, cnt_n;
  logic        done_n;
  logic [3:0]  tens_n, ones_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      done  <= done_n;
      tens  <= tens_n;
      ones  <= ones_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    tens_n  = tens;
    ones_n  = ones;
    // Add-3 correction of each BCD nibble before the shift.
    adj = sr;
    if (sr[8:5] >= 4'd5)  adj[8:5]  = sr[8:5] + 4'd3;
    if (sr[12:9] >= 4'd5) adj[12:9] = sr[12:9] + 4'd3;
    case (state)
      IDLE: begin
        if (start) begin
          sr_n    = {8'd0, cout_in, sum_in};
          cnt_n   = ITER_COUNT;
          state_n = CONV;
        end
      end
      CONV: begin
        sr_n  = {adj[11:0], 1'b0};
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = DONE;
      end
      DONE: begin
        tens_n  = sr[12:9];
        ones_n  = sr[8:5];
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------- display scan ----------------
  logic [CW-1:0] scan_cnt;
  logic          tens_act;
  logic          scan_wrap;
  logic          tens_act_n;
  logic [3:0]    shown;
  logic [6:0]    dec_seg;
  logic          blank;

  assign scan_wrap  = (scan_cnt == CW'(SCAN_DIV - 1));
  assign tens_act_n = scan_wrap ? ~tens_act : tens_act;
  // Decode the digit that will be active after this edge so seg and
  // dig_sel stay aligned in the same register stage.
  assign shown      = tens_act_n ? tens : ones;
  assign blank      = tens_act_n && BLANK_LZ && (tens == 4'd0);

  seg7_decoder u_dec (
    .bcd (shown),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      tens_act <= 1'b0;
      dig_sel  <= DIG_ONES;
      seg      <= SEG_0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CW'(1);
      tens_act <= tens_act_n;
      dig_sel  <= tens_act_n ? DIG_TENS : DIG_ONES;
      seg      <= blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: directed conversions with hand-computed
// results pushed into an expected queue, a monitor popping on done, and
// direct checks of reset values, handshake timing and display scanning.
module tb_sum_bcd_display;

  logic       clk;
  logic       rst;
  logic [3:0] sum_in;
  logic       cout_in;
  logic       start;
  logic       busy, done;
  logic [3:0] tens, ones;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  // Second instance with leading-zero blanking disabled, sharing inputs.
  logic       busy_nb, done_nb;
  logic [3:0] tens_nb, ones_nb;
  logic [6:0] seg_nb;
  logic [1:0] dig_sel_nb;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  sum_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .cout_in(cout_in), .start(start),
    .busy(busy), .done(done), .tens(tens), .ones(ones), .seg(seg),
    .dig_sel(dig_sel)
  );

  sum_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .sum_in(sum_in), .cout_in(cout_in), .start(start),
    .busy(busy_nb), .done(done_nb), .tens(tens_nb), .ones(ones_nb),
    .seg(seg_nb), .dig_sel(dig_sel_nb)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual tens=%0d ones=%0d required no done", tens, ones);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("result", {24'd0, tens, ones}, {24'd0, e});
      end
    end
  end

  // ---------------- driver ----------------
  // Issues a start at edge k with value v and watches 12 cycles.
  // v2 >= 0 : second start with value v2 sampled at edge k+2.
  // rst_at > 0 : reset sampled at edge k+rst_at (conversion aborted).
  task automatic run_conv(input int v, input logic [7:0] exp, input int v2, input int rst_at);
    int lat;
    int ndone;
    bit expect_done;
    expect_done = (rst_at <= 0);
    lat = -1;
    ndone = 0;
    @(negedge clk);
    sum_in  = 4'(v);
    cout_in = v[4];
    start   = 1'b1;
    if (expect_done) exp_q.push_back(exp);
    @(posedge clk);  // edge k
    #1 start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);  // between edge k+c and k+c+1
      if (c == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (rst_at > 0 && c == rst_at) begin
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_digits", {24'd0, tens, ones}, 32'd0);
      end
      rst = 1'b0;
      if (v2 >= 0 && c == 1) begin
        sum_in  = 4'(v2);
        cout_in = v2[4];
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rst_at > 0 && c == rst_at - 1) rst = 1'b1;
    end
    if (expect_done) begin
      chk("done_count", ndone, 1);
      chk("done_latency", lat, 6);
    end else begin
      chk("no_done_on_abort", ndone, 0);
    end
  endtask

  // Observes the scan for n cycles: slot lengths and slot contents.
  task automatic check_scan(input int n, input logic [6:0] ones_pat,
                            input logic [6:0] tens_pat, input logic [6:0] tens_pat_nb);
    logic [1:0] prev;
    int run;
    bit first;
    prev  = dig_sel;
    run   = 0;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dig_sel != prev) begin
        if (!first) chk("scan_slot_len", run, 4);
        first = 1'b0;
        run = 1;
        prev = dig_sel;
      end else begin
        run++;
      end
      if (dig_sel == 2'b10) begin
        chk("seg_ones_slot", {25'd0, seg}, {25'd0, ones_pat});
      end else if (dig_sel == 2'b01) begin
        chk("seg_tens_slot", {25'd0, seg}, {25'd0, tens_pat});
        chk("seg_tens_slot_nolz", {25'd0, seg_nb}, {25'd0, tens_pat_nb});
      end else begin
        chk("dig_sel_code", {30'd0, dig_sel}, 32'h2);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    sum_in = 4'd0;
    cout_in = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tens", {28'd0, tens}, 32'd0);
    chk("rst_ones", {28'd0, ones}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dig_sel", {30'd0, dig_sel}, 32'h2);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dig_sel", {30'd0, dig_sel}, 32'h2);
    chk("post_rst_seg", {25'd0, seg}, 32'h40);

    // Directed vectors: 17, 31, 0, 9, 20.
    run_conv(17, 8'h17, -1, 0);
    run_conv(31, 8'h31, -1, 0);
    run_conv(0,  8'h00, -1, 0);
    run_conv(9,  8'h09, -1, 0);
    run_conv(20, 8'h20, -1, 0);

    // Sweep of all inputs against value/10, value%10.
    for (int v = 0; v < 32; v++) run_conv(v, {4'(v / 10), 4'(v % 10)}, -1, 0);

    // Second start while busy is dropped.
    run_conv(12, 8'h12, 5, 0);
    chk("ignored_start_digits", {24'd0, tens, ones}, 32'h12);

    // Reset at k+3 aborts the conversion of 25, then a normal retry.
    run_conv(25, 8'h25, -1, 3);
    run_conv(25, 8'h25, -1, 0);

    // Display content: value 5 -> ones slot 12, tens slot blank / 40.
    run_conv(5, 8'h05, -1, 0);
    check_scan(20, 7'h12, 7'h7F, 7'h40);

    // Two-digit display: 31 -> ones 79, tens 30 on both instances.
    run_conv(31, 8'h31, -1, 0);
    check_scan(12, 7'h79, 7'h30, 7'h30);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
